winograd_tile_feeder: RTL
=========================

// Module: winograd_tile_feeder
// PURPOSE
//   Upstream feeder for winograd2d: accepts a raster-order stream of signed 8-bit pixels and buffers the
//   last 4 image rows. Emits overlapping 4x4 input tiles (stride 2 in both axes) as four packed row words
//   (r1_x..r4_x), with a valid/ready handshake. Each tile produces one 2x2 F(2x2,3x3) output block.
// PARAMETERS
//   IMG_W   16   image width in pixels; even, 4..256
//   IMG_H   16   image height in pixels; even, 4..256
// PORTS
//   clk         in   1   clock; all state updates on posedge
//   rst         in   1   asynchronous, active-low reset
//   clear       in   1   synchronous frame abort; 1-cycle pulse
//   in_valid    in   1   in_pixel valid
//   in_ready    out  1   feeder can accept a pixel this cycle
//   in_pixel    in   8   signed pixel, raster order (row-major, col 0 first)
//   out_valid   out  1   tile words valid
//   out_ready   in   1   downstream accepts tile
//   r1_x..r4_x  out  32  tile rows top..bottom; [31:24]=leftmost col, [7:0]=rightmost col
//   tile_row    out  8   tile top-left row / 2
//   tile_col    out  8   tile top-left col / 2
//   frame_done  out  1   1-cycle pulse after the last pixel of a frame is accepted
// BEHAVIOUR
//   - Reset (rst=0, async): col=0, row=0, out_valid=0, r*_x=0, tile_row=0, tile_col=0, frame_done=0.
//     Line-buffer contents are not cleared; stale data is never emitted because tiles need 4 fresh rows.
//   - Accept: pixel is accepted when in_valid && in_ready.
//     in_ready = !(out_valid && !out_ready), i.e. a stalled tile blocks input; no combinational
//     path from in_valid.
//   - Storage: 4 x IMG_W x 8b register array; row r writes slot r%4, column col.
//     Counters col in 0..IMG_W-1 and row in 0..IMG_H-1 advance per accepted pixel.
//     col wraps to 0 and row increments; at (IMG_H-1, IMG_W-1) both wrap to 0.
//   - Tile trigger: accepted pixel with row odd, row>=3, col odd, col>=3.
//     On the next edge out_valid=1 and the outputs are set as follows:
//       r(k+1)_x = pixels (row-3+k, col-3..col), k=0..3, assembled from the buffer plus the
//       incoming pixel (bypass).
//       tile_row = (row-3)/2 and tile_col = (col-3)/2.
//   - Latency: 1 cycle from the accepting edge of the bottom-right pixel to out_valid.
//   - Output hold: out_valid and all tile fields are stable until out_valid && out_ready.
//     If a new trigger coincides with that handshake, the register reloads (back-to-back tiles).
//     Otherwise out_valid drops on handshake.
//   - Throughput: at most 1 tile per 2 accepted pixels; single output register suffices.
//   - Tiles per frame: ((IMG_W-2)/2)*((IMG_H-2)/2), which is 49 for 16x16.
//   - frame_done: registered pulse the cycle after the last pixel of a frame is accepted.
//     It coincides with out_valid of the final tile.
//   - clear=1: col=0, row=0, out_valid=0, frame_done=0 next edge.
//     clear overrides accept and trigger in the same cycle; the pixel presented that cycle is dropped.
//   - Sign: bytes are packed verbatim (two's complement); no extension or arithmetic in this block.
//   - Reset mid-frame: all outputs return to reset values immediately; the next accepted pixel is (0,0).
// TESTING
//   1. IMG_W=IMG_H=4, pixels 0x00..0x0F, out_ready=1:
//      exactly one tile, r1_x=0x00010203, r4_x=0x0C0D0E0F.
//      tile_row=tile_col=0; frame_done with out_valid.
//   2. 16x16, pixel=(row*16+col)&0xFF, out_ready=1, continuous valid:
//      49 tiles in raster order.
//      Tile (1,2) has r1_x=0x24252627; frame_done once.
//   3. Backpressure: out_ready=0 for 10 cycles at first tile. Required: in_ready=0 throughout,
//      outputs stable, no pixel lost; after release the remaining tiles match scenario 2.
//   4. Negative pixels: all pixels 0x80 on 4x4 -> r1_x..r4_x=0x80808080 (no sign smear into other bytes).
//   5. clear after 37 pixels of a 16x16 frame, then a full new frame.
//      Required: 49 correct tiles, none from the aborted data.
//   6. rst low mid-tile-stall: out_valid, frame_done and r*_x go 0 immediately;
//      a subsequent full frame gives 49 correct tiles.

Source files
------------

// File: rtl/winograd_tile_feeder.sv
`default_nettype none
// ============================================================================
// Module   : winograd_tile_feeder
// Purpose  : Buffers the last four rows of a raster-order stream of signed
//            8-bit pixels and emits overlapping 4x4 tiles (stride 2 in both
//            axes) for a downstream F(2x2,3x3) Winograd engine.
// Ports    : clk, rst (async, active-low), clear (sync frame abort)
//            in_valid/in_ready/in_pixel   - pixel stream, raster order
//            out_valid/out_ready          - tile handshake
//            r1_x..r4_x                   - tile rows top..bottom,
//                                           [31:24] = leftmost column
//            tile_row/tile_col            - tile top-left position / 2
//            frame_done                   - pulse after the last pixel
// Revision : 1.0 - initial release
// ============================================================================
module winograd_tile_feeder #(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_pixel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] r1_x,
  output logic [31:0] r2_x,
  output logic [31:0] r3_x,
  output logic [31:0] r4_x,
  output logic [7:0]  tile_row,
  output logic [7:0]  tile_col,
  output logic        frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] c_col_last  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] c_row_last  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] c_col_three = CW'(3);
  localparam logic [RW-1:0] c_row_three = RW'(3);
  localparam logic [CW-1:0] c_col_one   = CW'(1);
  localparam logic [RW-1:0] c_row_one   = RW'(1);

  // Four-row circular line buffer; image row r lives in slot r % 4.
  logic [7:0]    r_buf [4][IMG_W];

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_out_valid;
  logic          r_frame_done;
  logic [31:0]   r_tile [4];
  logic [7:0]    r_tile_row;
  logic [7:0]    r_tile_col;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_trigger;
  logic          w_col_last;
  logic          w_row_last;
  logic [CW-1:0] w_col_base;
  logic [RW-1:0] w_row_base;
  logic [31:0]   w_tile [4];

  // A held tile blocks the input; no path from in_valid to in_ready.
  assign w_in_ready = !(r_out_valid && !out_ready);
  // clear drops the pixel presented in the same cycle.
  assign w_accept   = in_valid && w_in_ready && !clear;
  assign w_col_last = (r_col == c_col_last);
  assign w_row_last = (r_row == c_row_last);

  // The incoming pixel completes a tile when it is the bottom-right corner
  // of a stride-2 window, i.e. odd row/col at least 3.
  assign w_trigger  = w_accept && r_row[0] && (r_row >= c_row_three) &&
                      r_col[0] && (r_col >= c_col_three);

  assign w_col_base = r_col - c_col_three;
  assign w_row_base = r_row - c_row_three;

  // Tile assembly. Row (row-3+k) sits in slot (row+1+k) % 4. The bottom-right
  // byte is still in flight, so it bypasses the buffer.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_tile[k] = '0;
      for (int j = 0; j < 4; j++) begin
        if (k == 3 && j == 3) begin
          w_tile[k][31-8*j -: 8] = in_pixel;
        end else begin
          w_tile[k][31-8*j -: 8] =
            r_buf[r_row[1:0] + 2'(k + 1)][r_col - CW'(3 - j)];
        end
      end
    end
  end

  // Line buffer is deliberately not reset: a tile always needs four rows
  // written after the last reset/clear, so stale bytes never reach the output.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_row[1:0]][r_col] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_tile       <= '{default: '0};
      r_tile_row   <= '0;
      r_tile_col   <= '0;
    end else if (clear) begin
      r_col        <= '0;
      r_row        <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_accept && w_col_last && w_row_last;

      if (w_accept) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + c_row_one;
        end else begin
          r_col <= r_col + c_col_one;
        end
      end

      // A trigger can only occur while the output register is empty or being
      // drained this cycle (in_ready gates it), so loading wins over dropping.
      if (w_trigger) begin
        r_out_valid <= 1'b1;
        r_tile      <= w_tile;
        r_tile_row  <= 8'(w_row_base >> 1);
        r_tile_col  <= 8'(w_col_base >> 1);
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign r1_x       = r_tile[0];
  assign r2_x       = r_tile[1];
  assign r3_x       = r_tile[2];
  assign r4_x       = r_tile[3];
  assign tile_row   = r_tile_row;
  assign tile_col   = r_tile_col;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire
